// File: rtl/fruit_field.sv
// fruit_field: slot-based fruit manager (spawn, hang, fall, pop, free) with per-pixel priority hit test.
// Optional FRUIT_HEIGHT_BONUS_EN adds a drop-height bonus to the collected score.
module fruit_field #(
  parameter int N_FRUITS   = 4,
  parameter int OBJ_W      = 16,
  parameter int OBJ_H      = 16,
  parameter int TYPE_W     = 2,
  parameter int FALL_SPEED = 4,
  parameter int FLOOR_Y    = 440,
  parameter int POP_FRAMES = 16,
  parameter int BASE_SCORE = 100
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic                startOfFrame,
  input  logic signed [10:0]  pixelX,
  input  logic signed [10:0]  pixelY,
  input  logic                spawnValid,
  output logic                spawnReady,
  input  logic signed [10:0]  spawnX,
  input  logic signed [10:0]  spawnY,
  input  logic [TYPE_W-1:0]   spawnType,
  input  logic                hitPlayer,
  input  logic                hitEnemy,
  output logic                drawingRequest,
  output logic [10:0]         offsetX,
  output logic [10:0]         offsetY,
  output logic [TYPE_W-1:0]   fruitChoice,
  output logic [2:0]          drawSlot,
  output logic                scoreValid,
  output logic [15:0]         scoreValue,
  output logic [N_FRUITS-1:0] activeMask
);
  localparam logic [1:0] FREE = 2'd0, HANG = 2'd1, FALL = 2'd2, POP = 2'd3;
  logic [1:0]         st_q [N_FRUITS];
  logic [1:0]         st_d [N_FRUITS];
  logic signed [10:0] x_q  [N_FRUITS];
  logic signed [10:0] y_q  [N_FRUITS];
  logic signed [10:0] y_d  [N_FRUITS];
  logic [TYPE_W-1:0]  t_q  [N_FRUITS];
  logic [7:0]         pc_q [N_FRUITS];
  logic [7:0]         pc_d [N_FRUITS];
  logic signed [11:0] dx   [N_FRUITS];
  logic signed [11:0] dy   [N_FRUITS];
  logic [N_FRUITS-1:0] hit;
  logic [2:0]         h_idx, sp_idx;
  logic [10:0]        h_ox, h_oy;
  logic [TYPE_W-1:0]  h_t;
  logic               spawn, col_any;
  logic [15:0]        col_val;
  logic               dr_q, sv_q;
  logic [10:0]        offx_q, offy_q;
  logic [TYPE_W-1:0]  ch_q;
  logic [2:0]         slot_q;
  logic [15:0]        sc_q;
`ifdef FRUIT_HEIGHT_BONUS_EN
  logic signed [10:0] sy_q [N_FRUITS];
  logic signed [10:0] col_y, col_sy;
  logic [11:0]        rise;
  logic [16:0]        sum;
`endif
  // Descending scan so the lowest-index hit / free slot wins.
  always_comb begin
    hit = '0;
    activeMask = '0;
    h_idx = '0;
    h_ox = '0;
    h_oy = '0;
    h_t = '0;
    sp_idx = '0;
    for (int i = N_FRUITS - 1; i >= 0; i--) begin
      activeMask[i] = st_q[i] != FREE;
      dx[i] = {pixelX[10], pixelX} - {x_q[i][10], x_q[i]};
      dy[i] = {pixelY[10], pixelY} - {y_q[i][10], y_q[i]};
      hit[i] = (st_q[i] == HANG || st_q[i] == FALL || (st_q[i] == POP && !pc_q[i][1]))
               && dx[i] >= 0 && dx[i] < OBJ_W && dy[i] >= 0 && dy[i] < OBJ_H;
      if (hit[i]) begin
        h_idx = 3'(i);
        h_ox = dx[i][10:0];
        h_oy = dy[i][10:0];
        h_t = t_q[i];
      end
      if (st_q[i] == FREE) sp_idx = 3'(i);
    end
  end
  assign spawnReady = ~&activeMask;
  assign spawn = spawnValid && spawnReady;
  always_comb begin
    col_any = 1'b0;
`ifdef FRUIT_HEIGHT_BONUS_EN
    col_y = '0;
    col_sy = '0;
`endif
    for (int i = 0; i < N_FRUITS; i++) begin
      st_d[i] = st_q[i];
      y_d[i] = y_q[i];
      pc_d[i] = pc_q[i];
      if (dr_q && slot_q == 3'(i) && hitEnemy && st_q[i] == FALL) begin
        st_d[i] = POP;
        pc_d[i] = '0;
        col_any = 1'b1;
`ifdef FRUIT_HEIGHT_BONUS_EN
        col_y = y_q[i];
        col_sy = sy_q[i];
`endif
      end else if (dr_q && slot_q == 3'(i) && hitPlayer && st_q[i] == HANG) begin
        st_d[i] = FALL;
      end else if (startOfFrame && st_q[i] == FALL) begin
        y_d[i] = y_q[i] + 11'(FALL_SPEED);
        st_d[i] = (y_d[i] >= FLOOR_Y) ? FREE : FALL;
      end else if (startOfFrame && st_q[i] == POP) begin
        st_d[i] = (pc_q[i] == 8'(POP_FRAMES - 1)) ? FREE : POP;
        pc_d[i] = pc_q[i] + 8'd1;
      end
      if (spawn && sp_idx == 3'(i)) st_d[i] = HANG;
    end
`ifdef FRUIT_HEIGHT_BONUS_EN
    rise = {col_y[10], col_y} - {col_sy[10], col_sy};
    sum = 17'(BASE_SCORE) + 17'(rise[11:2]);
    col_val = sum[16] ? 16'hFFFF : sum[15:0];
`else
    col_val = 16'(BASE_SCORE);
`endif
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < N_FRUITS; i++) begin
        st_q[i] <= FREE;
        x_q[i] <= '0;
        y_q[i] <= '0;
        t_q[i] <= '0;
        pc_q[i] <= '0;
`ifdef FRUIT_HEIGHT_BONUS_EN
        sy_q[i] <= '0;
`endif
      end
      dr_q <= 1'b0;
      offx_q <= '0;
      offy_q <= '0;
      ch_q <= '0;
      slot_q <= '0;
      sv_q <= 1'b0;
      sc_q <= '0;
    end else begin
      for (int i = 0; i < N_FRUITS; i++) begin
        st_q[i] <= st_d[i];
        y_q[i] <= y_d[i];
        pc_q[i] <= pc_d[i];
        if (spawn && sp_idx == 3'(i)) begin
          x_q[i] <= spawnX;
          y_q[i] <= spawnY;
          t_q[i] <= spawnType;
`ifdef FRUIT_HEIGHT_BONUS_EN
          sy_q[i] <= spawnY;
`endif
        end
      end
      dr_q <= |hit;
      if (|hit) begin
        offx_q <= h_ox;
        offy_q <= h_oy;
        ch_q <= h_t;
        slot_q <= h_idx;
      end
      sv_q <= col_any;
      if (col_any) sc_q <= col_val;
    end
  end
  assign drawingRequest = dr_q;
  assign offsetX = offx_q;
  assign offsetY = offy_q;
  assign fruitChoice = ch_q;
  assign drawSlot = slot_q;
  assign scoreValid = sv_q;
  assign scoreValue = sc_q;
endmodule

// File: tb/tb_fruit_field.sv
// tb_fruit_field: directed checks of spawn, priority hit test, fall, collect, pop blink, floor and async reset.
module tb_fruit_field;
  logic clk = 1'b0, resetN = 1'b0, startOfFrame = 1'b0, spawnValid = 1'b0;
  logic hitPlayer = 1'b0, hitEnemy = 1'b0;
  logic signed [10:0] pixelX = '0, pixelY = '0, spawnX = '0, spawnY = '0;
  logic [1:0] spawnType = '0;
  logic spawnReady, drawingRequest, scoreValid;
  logic [10:0] offsetX, offsetY;
  logic [1:0] fruitChoice;
  logic [2:0] drawSlot;
  logic [15:0] scoreValue;
  logic [3:0] activeMask;
  int total = 0, bad = 0;
  fruit_field dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY),
    .spawnValid(spawnValid), .spawnReady(spawnReady),
    .spawnX(spawnX), .spawnY(spawnY), .spawnType(spawnType),
    .hitPlayer(hitPlayer), .hitEnemy(hitEnemy),
    .drawingRequest(drawingRequest), .offsetX(offsetX), .offsetY(offsetY),
    .fruitChoice(fruitChoice), .drawSlot(drawSlot),
    .scoreValid(scoreValid), .scoreValue(scoreValue), .activeMask(activeMask)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic frame();
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    tick();
  endtask
  task automatic put(input int x, input int y, input int t);
    spawnValid = 1'b1;
    spawnX = 11'(x);
    spawnY = 11'(y);
    spawnType = 2'(t);
    tick();
    spawnValid = 1'b0;
  endtask
  task automatic pix(input int x, input int y);
    pixelX = 11'(x);
    pixelY = 11'(y);
  endtask
  initial begin
    #12;
    chk("rst_mask", 32'(activeMask), 0);
    chk("rst_dr", 32'(drawingRequest), 0);
    chk("rst_sv", 32'(scoreValid), 0);
    chk("rst_score", 32'(scoreValue), 0);
    @(negedge clk);
    resetN = 1'b1;
    tick();
    pix(105, 55);
    put(100, 50, 2);
    chk("sp1_mask", 32'(activeMask), 1);
    tick();
    chk("sp1_dr", 32'(drawingRequest), 1);
    chk("sp1_offx", 32'(offsetX), 5);
    chk("sp1_offy", 32'(offsetY), 5);
    chk("sp1_type", 32'(fruitChoice), 2);
    chk("sp1_slot", 32'(drawSlot), 0);
    pix(110, 52);
    put(108, 50, 1);
    put(300, 300, 3);
    chk("ready3", 32'(spawnReady), 1);
    put(400, 300, 0);
    chk("ready_full", 32'(spawnReady), 0);
    chk("mask_full", 32'(activeMask), 15);
    put(500, 300, 1);
    chk("mask_5th", 32'(activeMask), 15);
    chk("prio_slot", 32'(drawSlot), 0);
    chk("prio_offx", 32'(offsetX), 10);
    chk("prio_offy", 32'(offsetY), 2);
    hitPlayer = 1'b1;
    tick();
    hitPlayer = 1'b0;
    repeat (10) frame();
    pix(100, 89);
    tick();
    chk("fall_above", 32'(drawingRequest), 0);
    pix(100, 90);
    tick();
    chk("fall_dr", 32'(drawingRequest), 1);
    chk("fall_slot", 32'(drawSlot), 0);
    chk("fall_offy", 32'(offsetY), 0);
    hitEnemy = 1'b1;
    tick();
    hitEnemy = 1'b0;
    chk("col_sv", 32'(scoreValid), 1);
    chk("col_score", 32'(scoreValue), 100);
    tick();
    chk("col_sv_end", 32'(scoreValid), 0);
    chk("col_hold", 32'(scoreValue), 100);
    chk("pop_vis", 32'(drawingRequest), 1);
    frame();
    frame();
    chk("pop_blink", 32'(drawingRequest), 0);
    repeat (13) frame();
    chk("pop_15", 32'(activeMask), 15);
    frame();
    chk("pop_free", 32'(activeMask), 14);
    chk("pop_ready", 32'(spawnReady), 1);
    pix(100, 436);
    put(100, 436, 1);
    tick();
    chk("fl_dr", 32'(drawingRequest), 1);
    chk("fl_slot", 32'(drawSlot), 0);
    hitPlayer = 1'b1;
    tick();
    hitPlayer = 1'b0;
    chk("fl_alive", 32'(activeMask), 15);
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
    chk("fl_free", 32'(activeMask), 14);
    tick();
    chk("fl_nosv", 32'(scoreValid), 0);
    pix(100, 196);
    put(100, 196, 3);
    tick();
    hitPlayer = 1'b1;
    tick();
    hitPlayer = 1'b0;
    frame();
    pix(100, 200);
    tick();
    chk("both_pre", 32'(drawingRequest), 1);
    hitEnemy = 1'b1;
    startOfFrame = 1'b1;
    tick();
    hitEnemy = 1'b0;
    startOfFrame = 1'b0;
    chk("both_sv", 32'(scoreValid), 1);
    tick();
    chk("both_dr", 32'(drawingRequest), 1);
    chk("both_offy", 32'(offsetY), 0);
    chk("both_type", 32'(fruitChoice), 3);
    #2 resetN = 1'b0;
    #1;
    chk("arst_mask", 32'(activeMask), 0);
    chk("arst_dr", 32'(drawingRequest), 0);
    chk("arst_score", 32'(scoreValue), 0);
    chk("arst_type", 32'(fruitChoice), 0);
    chk("arst_sv", 32'(scoreValid), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
